// File: rtl/vhdl_string_lim_if.sv
// Character stream bundle between the string source and a byte consumer.
// No storage: this is wiring only, so it adds no latency.
// The consumer throttles the source with ch_ready, and data holds while ready is low.
interface vhdl_string_lim_if;
  logic [7:0] ch_data;
  logic       ch_valid;
  logic       ch_last;
  logic [1:0] ch_sel;
  logic       ch_ready;

  // Source side drives the character beat and samples ready.
  modport master (
    output ch_data,
    output ch_valid,
    output ch_last,
    output ch_sel,
    input  ch_ready
  );

  // Consumer side samples the beat and drives ready.
  modport slave (
    input  ch_data,
    input  ch_valid,
    input  ch_last,
    input  ch_sel,
    output ch_ready
  );
endinterface

// File: rtl/vhdl_string_lim.sv
// Constant string source: a="test string", b="a", c="abcde", streamed as a->b->c bytes on start.
// Latency: start sampled at edge N gives the first beat in cycle N+1, then one beat per accepted cycle.
// Backpressure: while ch_ready is low, the beat (data/sel/last) holds. Macro STR_NUL_SEP_EN adds a NUL after each string.
module vhdl_string_lim (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [87:0]       a,
  output logic [7:0]        b,
  output logic [39:0]       c,
  output logic              busy,
  vhdl_string_lim_if.master ch
);

  localparam logic [87:0] A_STR = 88'h74657374_20737472_696E67;
  localparam logic [7:0]  B_STR = 8'h61;
  localparam logic [39:0] C_STR = 40'h61_62_63_64_65;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

`ifdef STR_NUL_SEP_EN
  localparam logic [4:0] LAST_IDX = 5'd19;
`else
  localparam logic [4:0] LAST_IDX = 5'd16;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [9:0] beat;
  logic       sending;

  // The strings are plain constants, independent of clock, reset and start.
  assign a = A_STR;
  assign b = B_STR;
  assign c = C_STR;

  // Beat table: index -> {source select, character}. Order is a, then b, then c.
  function automatic logic [9:0] beat_lut(input logic [4:0] idx);
    logic [9:0] r;
    r = 10'd0;
    case (idx)
      5'd0:  r = {SEL_A, 8'h74};  // t
      5'd1:  r = {SEL_A, 8'h65};  // e
      5'd2:  r = {SEL_A, 8'h73};  // s
      5'd3:  r = {SEL_A, 8'h74};  // t
      5'd4:  r = {SEL_A, 8'h20};  // space
      5'd5:  r = {SEL_A, 8'h73};  // s
      5'd6:  r = {SEL_A, 8'h74};  // t
      5'd7:  r = {SEL_A, 8'h72};  // r
      5'd8:  r = {SEL_A, 8'h69};  // i
      5'd9:  r = {SEL_A, 8'h6E};  // n
      5'd10: r = {SEL_A, 8'h67};  // g
`ifdef STR_NUL_SEP_EN
      5'd11: r = {SEL_A, 8'h00};  // NUL ends a
      5'd12: r = {SEL_B, 8'h61};  // a
      5'd13: r = {SEL_B, 8'h00};  // NUL ends b
      5'd14: r = {SEL_C, 8'h61};  // a
      5'd15: r = {SEL_C, 8'h62};  // b
      5'd16: r = {SEL_C, 8'h63};  // c
      5'd17: r = {SEL_C, 8'h64};  // d
      5'd18: r = {SEL_C, 8'h65};  // e
      5'd19: r = {SEL_C, 8'h00};  // NUL ends c, final beat
`else
      5'd11: r = {SEL_B, 8'h61};  // a
      5'd12: r = {SEL_C, 8'h61};  // a
      5'd13: r = {SEL_C, 8'h62};  // b
      5'd14: r = {SEL_C, 8'h63};  // c
      5'd15: r = {SEL_C, 8'h64};  // d
      5'd16: r = {SEL_C, 8'h65};  // e, final beat
`endif
      default: r = 10'd0;
    endcase
    return r;
  endfunction

  assign sending = (state_q == SEND);
  assign beat    = beat_lut(idx_q);

  // Outputs are decoded from state so that reset clears them asynchronously.
  always_comb begin
    ch.ch_valid = sending;
    ch.ch_data  = sending ? beat[7:0] : 8'h00;
    ch.ch_sel   = sending ? beat[9:8] : 2'd0;
    ch.ch_last  = sending && (idx_q == LAST_IDX);
    busy        = sending;
  end

  // Next state: start launches a stream from IDLE, and each accepted beat advances the index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = 5'd0;
        if (start) begin
          state_d = SEND;
        end
      end
      SEND: begin
        // start is deliberately not looked at here, so a mid-stream request is dropped.
        if (ch.ch_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end

  // State and index registers. Async reset aborts any stream in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_vhdl_string_lim.sv
// Directed bench for vhdl_string_lim: constants, reset, full stream, backpressure, ignored start, mid-stream reset.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_vhdl_string_lim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [87:0] a;
  logic [7:0]  b;
  logic [39:0] c;
  logic        busy;

  vhdl_string_lim_if bus();

  vhdl_string_lim dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .ch    (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [87:0] A_EXP = 88'h74657374_20737472_696E67;
  localparam logic [7:0]  B_EXP = 8'h61;
  localparam logic [39:0] C_EXP = 40'h6162636465;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_dat [20];
  logic [1:0] exp_sel [20];
  int         exp_n;

  logic [7:0] got_dat [$];
  logic [1:0] got_sel [$];
  logic       got_last [$];
  int         bad_busy, bad_hold, valid_cycles, first_lat;
  bit         tmo;

  task automatic build_exp();
    string sa;
    string sc;
    sa = "test string";
    sc = "abcde";
    exp_n = 0;
    for (int i = 0; i < sa.len(); i++) begin
      exp_dat[exp_n] = sa[i]; exp_sel[exp_n] = 2'd0; exp_n++;
    end
`ifdef STR_NUL_SEP_EN
    exp_dat[exp_n] = 8'h00; exp_sel[exp_n] = 2'd0; exp_n++;
`endif
    exp_dat[exp_n] = 8'h61; exp_sel[exp_n] = 2'd1; exp_n++;
`ifdef STR_NUL_SEP_EN
    exp_dat[exp_n] = 8'h00; exp_sel[exp_n] = 2'd1; exp_n++;
`endif
    for (int i = 0; i < sc.len(); i++) begin
      exp_dat[exp_n] = sc[i]; exp_sel[exp_n] = 2'd2; exp_n++;
    end
`ifdef STR_NUL_SEP_EN
    exp_dat[exp_n] = 8'h00; exp_sel[exp_n] = 2'd2; exp_n++;
`endif
  endtask

  // Launch one stream and record accepted beats. bp selects the ready pattern 1,0,0 repeating.
  // restart_at is the number of beats already taken when a stray start pulse is driven.
  task automatic run_stream(input bit bp, input int restart_at);
    logic [7:0] hold_d;
    logic [1:0] hold_s;
    logic       hold_l;
    bit         stalled;
    bit         done;
    bit         rdy;
    int         cyc;
    got_dat.delete(); got_sel.delete(); got_last.delete();
    bad_busy = 0; bad_hold = 0; valid_cycles = 0; first_lat = -1;
    stalled = 0; done = 0; cyc = 0;
    hold_d = 8'h00; hold_s = 2'd0; hold_l = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 300) begin
      if (bus.ch_valid === 1'b1) begin
        if (first_lat < 0) first_lat = cyc;
        valid_cycles++;
        if (busy !== 1'b1) bad_busy++;
        if (stalled && (bus.ch_data !== hold_d || bus.ch_sel !== hold_s || bus.ch_last !== hold_l))
          bad_hold++;
        rdy = bp ? (cyc % 3 == 0) : 1'b1;
        bus.ch_ready = rdy;
        start = (got_dat.size() == restart_at) ? 1'b1 : 1'b0;
        if (rdy) begin
          got_dat.push_back(bus.ch_data);
          got_sel.push_back(bus.ch_sel);
          got_last.push_back(bus.ch_last);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d = bus.ch_data; hold_s = bus.ch_sel; hold_l = bus.ch_last;
        end
      end else begin
        start = 1'b0;
        if (busy !== 1'b0) bad_busy++;
        if (got_dat.size() > 0) done = 1'b1;
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    tmo = !done;
    start = 1'b0;
    bus.ch_ready = 1'b0;
  endtask

  task automatic test_const();
    #1;
    n_checks++;
    if (a !== A_EXP) begin n_fail++; $display("FAIL const_a: got %h want %h", a, A_EXP); end
    n_checks++;
    if (b !== B_EXP) begin n_fail++; $display("FAIL const_b: got %h want %h", b, B_EXP); end
    n_checks++;
    if (c !== C_EXP) begin n_fail++; $display("FAIL const_c: got %h want %h", c, C_EXP); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.ch_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++;
    if (bus.ch_data !== 8'h00 || bus.ch_sel !== 2'd0 || bus.ch_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_beat: got data %h sel %0d last %b want 00/0/0", bus.ch_data, bus.ch_sel, bus.ch_last);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.ch_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start: got valid %b busy %b want 0/0", bus.ch_valid, busy);
    end
  endtask

  task automatic test_stream();
    run_stream(1'b0, -1);
    n_checks++;
    if (tmo) begin n_fail++; $display("FAIL stream_timeout: got timeout want completion"); end
    n_checks++;
    if (first_lat !== 0) begin n_fail++; $display("FAIL stream_latency: got %0d want 0", first_lat); end
    n_checks++;
    if (got_dat.size() !== exp_n) begin n_fail++; $display("FAIL stream_beats: got %0d want %0d", got_dat.size(), exp_n); end
    n_checks++;
    if (valid_cycles !== exp_n) begin n_fail++; $display("FAIL stream_cycles: got %0d want %0d", valid_cycles, exp_n); end
    n_checks++;
    if (bad_busy !== 0) begin n_fail++; $display("FAIL stream_busy: got %0d bad cycles want 0", bad_busy); end
    for (int i = 0; i < exp_n && i < got_dat.size(); i++) begin
      n_checks++;
      if (got_dat[i] !== exp_dat[i] || got_sel[i] !== exp_sel[i] || got_last[i] !== (i == exp_n - 1)) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got %h/%0d/%b want %h/%0d/%b", i + 1, got_dat[i], got_sel[i], got_last[i],
                 exp_dat[i], exp_sel[i], (i == exp_n - 1));
      end
    end
  endtask

  task automatic test_backpressure();
    run_stream(1'b1, -1);
    n_checks++;
    if (tmo || got_dat.size() !== exp_n) begin
      n_fail++; $display("FAIL bp_beats: got %0d (timeout %b) want %0d", got_dat.size(), tmo, exp_n);
    end
    n_checks++;
    if (bad_hold !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalls want 0", bad_hold); end
    n_checks++;
    if (bad_busy !== 0) begin n_fail++; $display("FAIL bp_busy: got %0d bad cycles want 0", bad_busy); end
    for (int i = 0; i < exp_n && i < got_dat.size(); i++) begin
      n_checks++;
      if (got_dat[i] !== exp_dat[i] || got_sel[i] !== exp_sel[i] || got_last[i] !== (i == exp_n - 1)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h/%0d/%b want %h/%0d", i + 1, got_dat[i], got_sel[i], got_last[i],
                 exp_dat[i], exp_sel[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    run_stream(1'b0, 4);
    n_checks++;
    if (tmo || got_dat.size() !== exp_n) begin
      n_fail++; $display("FAIL restart_beats: got %0d (timeout %b) want %0d", got_dat.size(), tmo, exp_n);
    end
    n_checks++;
    if (got_dat.size() > 5 && got_dat[5] !== exp_dat[5]) begin
      n_fail++; $display("FAIL restart_beat6: got %h want %h", got_dat[5], exp_dat[5]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.ch_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL restart_idle: got valid %b busy %b want 0/0", bus.ch_valid, busy);
    end
  endtask

  task automatic test_reset_midstream();
    bus.ch_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if (bus.ch_valid !== 1'b1 || bus.ch_data !== exp_dat[7]) begin
      n_fail++; $display("FAIL mid_beat8: got valid %b data %h want 1/%h", bus.ch_valid, bus.ch_data, exp_dat[7]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ch_valid !== 1'b0 || busy !== 1'b0 || bus.ch_data !== 8'h00 || bus.ch_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_abort: got valid %b busy %b data %h sel %0d want 0/0/00/0", bus.ch_valid, busy, bus.ch_data, bus.ch_sel);
    end
    n_checks++;
    if (a !== A_EXP || b !== B_EXP || c !== C_EXP) begin
      n_fail++; $display("FAIL mid_const: got %h %h %h want %h %h %h", a, b, c, A_EXP, B_EXP, C_EXP);
    end
    bus.ch_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(1'b0, -1);
    n_checks++;
    if (tmo || got_dat.size() !== exp_n) begin
      n_fail++; $display("FAIL mid_rerun_beats: got %0d (timeout %b) want %0d", got_dat.size(), tmo, exp_n);
    end
    n_checks++;
    if (got_dat.size() == 0 || got_dat[0] !== 8'h74 || got_sel[0] !== 2'd0) begin
      n_fail++; $display("FAIL mid_rerun_first: got %h want 74", (got_dat.size() > 0) ? got_dat[0] : 8'hxx);
    end
    n_checks++;
    if (a !== A_EXP || b !== B_EXP || c !== C_EXP) begin
      n_fail++; $display("FAIL end_const: got %h %h %h want %h %h %h", a, b, c, A_EXP, B_EXP, C_EXP);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    bus.ch_ready = 1'b0;
    build_exp();
    test_const();
    test_reset();
    test_stream();
    test_backpressure();
    test_start_ignored();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
